traffic_light_fsm: RTL and testbench

Single-intersection traffic-light controller: a Moore state machine that cycles RED → GREEN → YELLOW → RED, holding each phase for a parameterised number of clock cycles. It drives a 3-bit one-hot lamp bus. It sits directly behind the lamp drivers, has no other inputs, and runs freely once reset is released.

---
 rtl/traffic_light_fsm_if.sv | 20 ++
 rtl/traffic_light_fsm.sv | 78 +++++++
 tb/tb_traffic_light_fsm.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/traffic_light_fsm_if.sv
// Lamp bus between the traffic-light controller and the lamp drivers,
// plus the controller's state type shared with anything that needs it.
package traffic_light_pkg;
   typedef enum logic [1:0] {
      ST_RED    = 2'b00,
      ST_GREEN  = 2'b01,
      ST_YELLOW = 2'b10
   } state_t;

   localparam logic [2:0] LAMP_RED    = 3'b100;
   localparam logic [2:0] LAMP_YELLOW = 3'b010;
   localparam logic [2:0] LAMP_GREEN  = 3'b001;
endpackage

interface traffic_light_fsm_if;
   logic [2:0] lights;

   modport master (output lights);
   modport slave  (input  lights);
endinterface

// File: rtl/traffic_light_fsm.sv
// Free-running single-intersection traffic-light controller: RED -> GREEN -> YELLOW -> RED,
// each phase held for its parameterised number of cycles, one-hot lamp bus decoded from state.
module traffic_light_fsm
   import traffic_light_pkg::*;
#(
   parameter int RED_CYCLES    = 8,
   parameter int GREEN_CYCLES  = 10,
   parameter int YELLOW_CYCLES = 3
) (
   input  logic                clk,
   input  logic                rst,
   traffic_light_fsm_if.master lamps
);

   localparam int          MAX_RG = (RED_CYCLES > GREEN_CYCLES) ? RED_CYCLES : GREEN_CYCLES;
   localparam int          MAX_D  = (MAX_RG > YELLOW_CYCLES) ? MAX_RG : YELLOW_CYCLES;
   localparam int unsigned CNT_W  = (MAX_D > 1) ? $clog2(MAX_D) : 1;

   localparam logic [CNT_W-1:0] RED_LAST    = CNT_W'(RED_CYCLES - 1);
   localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYCLES - 1);
   localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYCLES - 1);

   // Zero-length phases are a configuration error, never clamped.
   if (RED_CYCLES < 1 || GREEN_CYCLES < 1 || YELLOW_CYCLES < 1) begin : g_cfg_err
      $error("traffic_light_fsm: every phase duration must be >= 1 cycle");
   end

   state_t             state;
   state_t             next_state;
   logic [CNT_W-1:0]   count;
   logic [CNT_W-1:0]   next_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_RED;
         count <= '0;
      end else begin
         state <= next_state;
         count <= next_count;
      end
   end

   // Phase sequencing plus Moore lamp decode; unused encodings fall back to RED.
   always_comb begin
      next_state   = state;
      next_count   = count + CNT_W'(1);
      lamps.lights = LAMP_RED;
      case (state)
         ST_RED: begin
            lamps.lights = LAMP_RED;
            if (count == RED_LAST) begin
               next_state = ST_GREEN;
               next_count = '0;
            end
         end
         ST_GREEN: begin
            lamps.lights = LAMP_GREEN;
            if (count == GREEN_LAST) begin
               next_state = ST_YELLOW;
               next_count = '0;
            end
         end
         ST_YELLOW: begin
            lamps.lights = LAMP_YELLOW;
            if (count == YELLOW_LAST) begin
               next_state = ST_RED;
               next_count = '0;
            end
         end
         default: begin
            lamps.lights = LAMP_RED;
            next_state   = ST_RED;
            next_count   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Scoreboarded bench for traffic_light_fsm: a cycle-position model predicts the lamp bus
// of a default and an all-ones instance under random runs, resets and illegal-state forcing.
module tb_traffic_light_fsm;

   localparam logic [2:0] L_RED    = 3'b100;
   localparam logic [2:0] L_GREEN  = 3'b001;
   localparam logic [2:0] L_YELLOW = 3'b010;

   logic clk     = 1'b0;
   logic rst     = 1'b1;
   logic clk_run = 1'b1;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   traffic_light_fsm_if lamps0 ();
   traffic_light_fsm_if lamps1 ();

   traffic_light_fsm dut (
      .clk   (clk),
      .rst   (rst),
      .lamps (lamps0)
   );

   traffic_light_fsm #(
      .RED_CYCLES    (1),
      .GREEN_CYCLES  (1),
      .YELLOW_CYCLES (1)
   ) dut_min (
      .clk   (clk),
      .rst   (rst),
      .lamps (lamps1)
   );

   always begin
      #5;
      if (clk_run) clk = ~clk;
   end

   task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: lights=%b expected %b at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Lamp colour after t edges of free running: position within the R+G+Y period.
   function automatic logic [2:0] model_lights(input int unsigned t, input int unsigned r,
                                               input int unsigned g, input int unsigned y);
      int unsigned p;
      p = t % (r + g + y);
      if (p < r) return L_RED;
      if (p < r + g) return L_GREEN;
      return L_YELLOW;
   endfunction

   int unsigned el0 = 0;
   int unsigned el1 = 0;
   bit          recover0 = 1'b0;
   logic [2:0]  q0[$];
   logic [2:0]  q1[$];

   always @(posedge rst) begin
      el0 = 0;
      el1 = 0;
   end

   // Reference side: one expected lamp value per edge for each instance.
   always @(posedge clk) begin
      if (rst) begin
         el0      = 0;
         el1      = 0;
         recover0 = 1'b0;
      end else begin
         if (recover0) begin
            el0      = 0;
            recover0 = 1'b0;
         end else begin
            el0++;
         end
         el1++;
      end
      q0.push_back(model_lights(el0, 8, 10, 3));
      q1.push_back(model_lights(el1, 1, 1, 1));
   end

   // Monitor: compare the presented lamp bus against the queued expectation.
   always @(negedge clk) begin
      logic [2:0] e0;
      logic [2:0] e1;
      if (q0.size() > 0) begin
         e0 = q0.pop_front();
         if (rst) e0 = L_RED;
         check("seq_default", lamps0.lights, e0);
         check_int("onehot_default", int'($onehot(lamps0.lights)), 1);
      end
      if (q1.size() > 0) begin
         e1 = q1.pop_front();
         if (rst) e1 = L_RED;
         check("seq_min", lamps1.lights, e1);
         check_int("onehot_min", int'($onehot(lamps1.lights)), 1);
      end
   end

   task automatic pulse_reset(input int unsigned hold);
      @(posedge clk);
      #($urandom_range(1, 4));
      rst = 1'b1;
      #1;
      check("reset_async_default", lamps0.lights, L_RED);
      check("reset_async_min", lamps1.lights, L_RED);
      repeat (hold) @(posedge clk);
      @(negedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic force_illegal();
      @(negedge clk);
      #1;
      force dut.state = traffic_light_pkg::state_t'(2'b11);
      #1;
      check("illegal_lights", lamps0.lights, L_RED);
      recover0 = 1'b1;
      #1;
      release dut.state;
   endtask

   initial begin
      int edges;

      repeat (3) @(posedge clk);
      #1;
      check("reset_clk_running_default", lamps0.lights, L_RED);
      check("reset_clk_running_min", lamps1.lights, L_RED);
      @(negedge clk);
      #1 rst = 1'b0;

      repeat (30) @(posedge clk);

      // Reset with the clock stopped, while the default instance is in GREEN.
      @(negedge clk);
      clk_run = 1'b0;
      #2;
      check("pre_stop_green", lamps0.lights, L_GREEN);
      rst = 1'b1;
      #1;
      check("reset_clk_stopped_default", lamps0.lights, L_RED);
      check("reset_clk_stopped_min", lamps1.lights, L_RED);
      #3 rst = 1'b0;
      #1 clk_run = 1'b1;

      // Reset mid-GREEN, then time the next GREEN from release.
      repeat (12) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("reset_mid_green", lamps0.lights, L_RED);
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1 rst = 1'b0;
      edges = 0;
      while (edges < 50 && lamps0.lights !== L_GREEN) begin
         @(posedge clk);
         edges++;
         #1;
      end
      check_int("green_after_release", edges, 8);

      force_illegal();

      for (int i = 0; i < 12; i++) begin
         repeat ($urandom_range(3, 40)) @(posedge clk);
         case ($urandom_range(0, 2))
            1: pulse_reset($urandom_range(1, 3));
            2: force_illegal();
            default: ;
         endcase
      end

      repeat (200) @(posedge clk);
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: run did not complete by t=%0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
